// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use LSB-first shift-add; DIV/DIVU use MSB-first restoring division.
// Both run on operand magnitudes and apply signs in a final FIX step, so the
// latency is WIDTH+2 cycles regardless of op or operand values.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_q;
  logic               is_div_q;
  logic               neg_q;      // result (product / quotient) negated
  logic               rem_neg_q;  // remainder negated (sign of dividend)
  logic               dbz_q;      // divide with zero divisor in flight
  logic               busy_q, ready_q, div_by_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Issue-time operand conditioning
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // Iteration / fix-up datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign busy        = busy_q;
  assign ready       = ready_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Operand magnitudes and signs of the incoming request
  always_comb begin
    sign_a = op[0] & a[WIDTH-1];
    sign_b = op[0] & b[WIDTH-1];
    mag_a  = sign_a ? ('0 - a) : a;
    mag_b  = sign_b ? ('0 - b) : b;
  end

  // Next accumulator/remainder for one RUN iteration or the FIX step
  always_comb begin
    acc_d     = acc_q;
    rem_d     = rem_q;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    prod_neg  = '0 - acc_q;
    q_fix     = neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    r_fix     = rem_neg_q ? ('0 - rem_q) : rem_q;
    case (state_q)
      StRun: begin
        if (is_div_q) begin
          rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_next;
        end
      end
      StFix: begin
        if (is_div_q) begin
          // Divide by zero: HI = raw dividend, LO = all ones.
          acc_d = dbz_q ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
        end else begin
          acc_d = neg_q ? prod_neg : acc_q;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, operand latches and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      acc_q         <= '0;
      rem_q         <= '0;
      opnd_q        <= '0;
      a_q           <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      div_by_zero_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q           <= a;
            is_div_q      <= op[1];
            neg_q         <= sign_a ^ sign_b;
            rem_neg_q     <= sign_a;
            dbz_q         <= op[1] & (b == '0);
            acc_q         <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            opnd_q        <= op[1] ? mag_b : mag_a;
            rem_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            div_by_zero_q <= 1'b0;
            state_q       <= StRun;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntMax) state_q <= StFix;
        end
        StFix: begin
          acc_q   <= acc_d;
          state_q <= StDone;
        end
        StDone: begin
          hi_q          <= acc_q[2*WIDTH-1:WIDTH];
          lo_q          <= acc_q[WIDTH-1:0];
          div_by_zero_q <= dbz_q;
          ready_q       <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): expected HI/LO/div_by_zero come
// from a reference model, queued at issue and compared at the ready pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, ready, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cur_hi, cur_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .ready      (ready),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op_v, input logic [31:0] av, input logic [31:0] bv);
    exp_t               e;
    logic [63:0]        up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sbv;
    e.dbz = 1'b0;
    sa    = av;
    sbv   = bv;
    case (op_v)
      2'b00: begin
        up = {32'b0, av} * {32'b0, bv};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      2'b01: begin
        sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      default: begin
        if (bv == 32'd0) begin
          e.hi  = av;
          e.lo  = 32'hFFFF_FFFF;
          e.dbz = 1'b1;
        end else if (op_v == 2'b10) begin
          e.lo = av / bv;
          e.hi = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'd0;
        end else begin
          e.lo = 32'(sa / sbv);
          e.hi = 32'(sa % sbv);
        end
      end
    endcase
    return e;
  endfunction

  // Drive one request from an off-edge point and follow it to its ready pulse.
  // disturb_at >= 0: at that many edges after accept, assert start + MTHI/MTLO.
  // mt_with_start: assert hi_we in the same cycle as start.
  task automatic issue(input logic [1:0] op_v, input logic [31:0] av, input logic [31:0] bv,
                       input int disturb_at, input logic mt_with_start);
    exp_t e;
    int   edges;
    int   busy_n;
    bit   seen;
    sb.push_back(model(op_v, av, bv));
    start = 1'b1;
    op    = op_v;
    a     = av;
    b     = bv;
    hi_we = mt_with_start;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_ready_low", 64'(ready), 64'd0);
    check("accept_dbz_cleared", 64'(div_by_zero), 64'd0);
    check("accept_hi_held", 64'(hi), 64'(cur_hi));
    busy_n = 1;
    edges  = 0;
    seen   = 1'b0;
    while (!seen && edges < 100) begin
      if (edges == disturb_at) begin
        start = 1'b1;
        op    = ~op_v;
        a     = 32'h0000_1111;
        b     = 32'h0000_0003;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
      end
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (edges == disturb_at + 1) begin
        check("mid_hi_held", 64'(hi), 64'(cur_hi));
        check("mid_lo_held", 64'(lo), 64'(cur_lo));
      end
      if (ready) seen = 1'b1;
      else if (busy) busy_n++;
    end
    check("ready_seen", 64'(seen), 64'd1);
    check("latency", 64'(edges), 64'd34);
    check("busy_cycles", 64'(busy_n), 64'd34);
    check("busy_low_at_ready", 64'(busy), 64'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("result_hi", 64'(hi), 64'(e.hi));
      check("result_lo", 64'(lo), 64'(e.lo));
      check("result_dbz", 64'(div_by_zero), 64'(e.dbz));
      cur_hi = e.hi;
      cur_lo = e.lo;
    end else begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end
  endtask

  initial begin
    int pulses;
    rst_b  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // MULT -3 * 7
    @(negedge clk);
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
    check("mult_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);

    // MULTU max*max, then DIV issued in the ready cycle
    @(negedge clk);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);

    // Signed overflow
    @(negedge clk);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);

    // DIVU by zero
    @(negedge clk);
    issue(2'b10, 32'd5, 32'd0, -1, 1'b0);
    check("divu_zero_dbz_const", 64'(div_by_zero), 64'd1);

    // Next start clears div_by_zero; hi_we with start and mid-RUN start/MTHI ignored
    @(negedge clk);
    issue(2'b00, 32'h0001_2345, 32'd3, 10, 1'b1);

    // MTLO / MTHI in IDLE
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi_held", 64'(hi), 64'(cur_hi));
    cur_lo = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'hABCD);
    check("mthi_lo_held", 64'(lo), 64'h1234);
    cur_hi = 32'h0000_ABCD;

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    check("midreset_ready", 64'(ready), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
    check("midreset_no_ready", 64'(pulses), 64'd0);
    cur_hi = '0;
    cur_lo = '0;

    // Fresh operations after reset
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd7, -1, 1'b0);
    @(negedge clk);
    issue(2'b11, 32'd1000, 32'hFFFF_FFF9, -1, 1'b0);
    @(negedge clk);
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, -1, 1'b0);
    @(negedge clk);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
    @(negedge clk);
    issue(2'b11, $urandom, $urandom_range(1, 1000), -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
